// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - FSM state encoding (binary, one state register)
//   - Default reset PC
//   - MIPS primary opcode constants (instr[31:26]), shared with the decoder and checkers
//   - Branch offset helper used by the next-PC logic
package instr_fetch_pkg;

    localparam int unsigned StateW = 2;

    localparam logic [StateW-1:0] ST_IDLE  = 2'd0;
    localparam logic [StateW-1:0] ST_FETCH = 2'd1;
    localparam logic [StateW-1:0] ST_VALID = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_RTYPE = 6'h00;
    localparam opcode_t OP_J     = 6'h02;
    localparam opcode_t OP_JAL   = 6'h03;
    localparam opcode_t OP_BEQ   = 6'h04;
    localparam opcode_t OP_BNE   = 6'h05;
    localparam opcode_t OP_ADDI  = 6'h08;
    localparam opcode_t OP_ORI   = 6'h0D;
    localparam opcode_t OP_LW    = 6'h23;
    localparam opcode_t OP_SW    = 6'h2B;

    // Word offset of a branch: sign-extend the 16-bit immediate and scale by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC selection for the instruction being consumed.
// Priority: jump > branch_taken > sequential. All adds wrap modulo 2^32.
//   pc_plus4_i      : PC of the presented instruction plus 4
//   branch_taken_i  : Branch AND Zero for the presented instruction
//   branch_imm_i    : 16-bit branch immediate (word offset)
//   jump_i          : Jump for the presented instruction
//   jump_index_i    : 26-bit jump target field
//   next_pc_o       : selected next PC
module instr_fetch_next_pc
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_imm_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] jump_target;
    logic [31:0] branch_target;

    // Jump keeps the 256 MB region of the delay-slot address.
    assign jump_target   = {pc_plus4_i[31:28], jump_index_i, 2'b00};
    assign branch_target = pc_plus4_i + branch_offset(branch_imm_i);

    always_comb begin
        next_pc_o = pc_plus4_i;
        if (jump_i) begin
            next_pc_o = jump_target;
        end else if (branch_taken_i) begin
            next_pc_o = branch_target;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, issues single-outstanding word reads over a
// req/ready handshake and presents the fetched instruction with its PC and PC+4 to decode.
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   imem_req_o        : read request, high only in FETCH
//   imem_addr_o       : word-aligned fetch address (the PC)
//   imem_ready_i      : read data valid; honoured only in FETCH
//   imem_rdata_i      : instruction word from memory
//   instr_o           : registered instruction presented to decode
//   instr_valid_o     : instr_o/pc_o/pc_plus4_o hold a valid instruction
//   pc_o, pc_plus4_o  : address of the presented instruction and that plus 4
//   stall_i           : downstream hold; instruction not consumed this cycle
//   branch_taken_i, branch_imm_i, jump_i, jump_index_i : redirect for the presented instruction
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_imm_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i
);

    logic [StateW-1:0] state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       pc_plus4;
    logic [31:0]       next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    instr_fetch_next_pc u_next_pc (
        .pc_plus4_i     (pc_plus4),
        .branch_taken_i (branch_taken_i),
        .branch_imm_i   (branch_imm_i),
        .jump_i         (jump_i),
        .jump_index_i   (jump_index_i),
        .next_pc_o      (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready_i) begin
                    instr_d = imem_rdata_i;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                // Redirect inputs only matter in the cycle the instruction is consumed.
                if (!stall_i) begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req_o    = (state_q == ST_FETCH);
    assign imem_addr_o   = {pc_q[31:2], 2'b00};
    assign instr_o       = instr_q;
    assign instr_valid_o = (state_q == ST_VALID);
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_plus4;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed steps followed by randomized fetch/consume
// traffic, checked against a PC/instruction reference model.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [15:0] branch_imm_i = 16'h0;
    logic        jump_i = 1'b0;
    logic [25:0] jump_index_i = 26'h0;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ready_i   (imem_ready_i),
        .imem_rdata_i   (imem_rdata_i),
        .instr_o        (instr_o),
        .instr_valid_o  (instr_valid_o),
        .pc_o           (pc_o),
        .pc_plus4_o     (pc_plus4_o),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .branch_imm_i   (branch_imm_i),
        .jump_i         (jump_i),
        .jump_index_i   (jump_index_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference next PC, straight from the architectural rules.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic br,
                                             input logic [15:0] imm, input logic j,
                                             input logic [25:0] idx);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ({6'd0, idx} << 2);
        if (br) return seq + 32'(int'($signed(imm)) * 4);
        return seq;
    endfunction

    task automatic scramble_redirect();
        stall_i        = 1'($urandom);
        branch_taken_i = 1'($urandom);
        branch_imm_i   = 16'($urandom);
        jump_i         = 1'($urandom);
        jump_index_i   = 26'($urandom);
    endtask

    // Entered at a negedge in FETCH; returns at the negedge where the instruction is valid.
    task automatic fetch(input int waits, input logic [31:0] data);
        int n;
        n = 0;
        while (!imem_req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", 32'(imem_req_o), 32'd1);
        chk("fetch_addr", imem_addr_o, m_pc);
        for (int i = 0; i < waits; i++) begin
            imem_ready_i = 1'b0;
            imem_rdata_i = $urandom;
            scramble_redirect();
            @(negedge clk);
            chk("wait_req", 32'(imem_req_o), 32'd1);
            chk("wait_addr", imem_addr_o, m_pc);
            chk("wait_valid", 32'(instr_valid_o), 32'd0);
        end
        imem_ready_i = 1'b1;
        imem_rdata_i = data;
        @(negedge clk);
        imem_ready_i = 1'b0;
        imem_rdata_i = $urandom;
        m_instr = data;
        chk("valid", 32'(instr_valid_o), 32'd1);
        chk("instr", instr_o, m_instr);
        chk("pc", pc_o, m_pc);
        chk("pc_plus4", pc_plus4_o, m_pc + 32'd4);
        chk("valid_req", 32'(imem_req_o), 32'd0);
    endtask

    // Entered at the first VALID negedge; returns at the first FETCH negedge of the next PC.
    task automatic consume(input int stalls, input logic br, input logic [15:0] imm,
                           input logic j, input logic [25:0] idx);
        for (int i = 0; i < stalls; i++) begin
            stall_i        = 1'b1;
            jump_i         = (i == 1) ? 1'b1 : 1'($urandom);
            branch_taken_i = 1'($urandom);
            branch_imm_i   = 16'($urandom);
            jump_index_i   = 26'($urandom);
            imem_ready_i   = 1'($urandom);
            imem_rdata_i   = $urandom;
            @(negedge clk);
            chk("stall_valid", 32'(instr_valid_o), 32'd1);
            chk("stall_instr", instr_o, m_instr);
            chk("stall_pc", pc_o, m_pc);
            chk("stall_req", 32'(imem_req_o), 32'd0);
        end
        stall_i        = 1'b0;
        imem_ready_i   = 1'b0;
        branch_taken_i = br;
        branch_imm_i   = imm;
        jump_i         = j;
        jump_index_i   = idx;
        @(negedge clk);
        m_pc = ref_next(m_pc, br, imm, j, idx);
        scramble_redirect();
        chk("next_req", 32'(imem_req_o), 32'd1);
        chk("next_addr", imem_addr_o, m_pc);
        chk("next_valid", 32'(instr_valid_o), 32'd0);
    endtask

    initial begin
        // Reset held: late/spurious ready must be ignored.
        m_pc = RST_PC;
        m_instr = 32'h0;
        repeat (2) begin
            imem_ready_i = 1'($urandom);
            imem_rdata_i = $urandom;
            @(negedge clk);
            chk("rst_req", 32'(imem_req_o), 32'd0);
            chk("rst_addr", imem_addr_o, RST_PC);
            chk("rst_instr", instr_o, 32'h0);
            chk("rst_valid", 32'(instr_valid_o), 32'd0);
            chk("rst_pc", pc_o, RST_PC);
        end
        // Release with ready high in IDLE; first request one cycle later.
        rst = 1'b0;
        imem_ready_i = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("idle_req", 32'(imem_req_o), 32'd0);
        @(negedge clk);
        chk("first_req", 32'(imem_req_o), 32'd1);
        chk("first_addr", imem_addr_o, 32'h0040_0000);
        chk("idle_instr", instr_o, 32'h0);

        fetch(0, {OP_ADDI, 26'h012_3456});
        consume(0, 1'b0, 16'h0, 1'b0, 26'h0);
        chk("plan_seq", imem_addr_o, 32'h0040_0004);
        fetch(3, {OP_LW, 26'h3AB_CDEF});
        consume(0, 1'b0, 16'h0, 1'b1, 26'h0);
        chk("plan_j0", imem_addr_o, 32'h0000_0000);
        fetch(0, $urandom);
        consume(0, 1'b1, 16'hFFFE, 1'b0, 26'h0);
        chk("plan_back", imem_addr_o, 32'hFFFF_FFFC);
        fetch(1, $urandom);
        consume(0, 1'b0, 16'h0, 1'b0, 26'h0);
        chk("plan_wrap", imem_addr_o, 32'h0000_0000);
        fetch(0, $urandom);
        consume(0, 1'b0, 16'h0, 1'b1, 26'h000_0040);
        chk("plan_j100", imem_addr_o, 32'h0000_0100);
        fetch(0, {OP_BEQ, 26'h000_FFFF});
        consume(0, 1'b1, 16'hFFFF, 1'b0, 26'h0);
        chk("plan_br_m1", imem_addr_o, 32'h0000_0100);
        fetch(0, {OP_BNE, 26'h000_0003});
        consume(0, 1'b1, 16'h0003, 1'b0, 26'h0);
        chk("plan_br_p3", imem_addr_o, 32'h0000_0110);
        fetch(0, {OP_J, 26'h000_0040});
        consume(0, 1'b0, 16'h0, 1'b1, 26'h000_0040);
        fetch(0, $urandom);
        consume(0, 1'b0, 16'hFFFF, 1'b0, 26'h0);
        chk("plan_nt", imem_addr_o, 32'h0000_0104);
        fetch(0, $urandom);
        consume(0, 1'b0, 16'h0, 1'b1, 26'h3FF_FFFF);
        chk("plan_jmax", imem_addr_o, 32'h0FFF_FFFC);
        fetch(2, $urandom);
        consume(0, 1'b0, 16'h0, 1'b0, 26'h0);
        chk("plan_carry", imem_addr_o, 32'h1000_0000);
        fetch(0, {OP_JAL, 26'h000_0040});
        consume(0, 1'b1, 16'h1234, 1'b1, 26'h000_0040);
        chk("plan_jprio", imem_addr_o, 32'h1000_0100);
        fetch(0, {OP_SW, 26'h155_5555});
        consume(4, 1'b0, 16'h0, 1'b0, 26'h0);
        chk("plan_stall", imem_addr_o, 32'h1000_0104);

        for (int k = 0; k < 40; k++) begin
            fetch(int'($urandom_range(0, 3)), $urandom);
            consume(int'($urandom_range(0, 2)), 1'($urandom), 16'($urandom), 1'($urandom),
                    26'($urandom));
        end

        // Reset in the middle of a FETCH, then a late ready around release.
        fetch(2, $urandom);
        consume(0, 1'b0, 16'h0, 1'b0, 26'h0);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(imem_req_o), 32'd0);
        chk("mid_rst_addr", imem_addr_o, RST_PC);
        chk("mid_rst_valid", 32'(instr_valid_o), 32'd0);
        chk("mid_rst_instr", instr_o, 32'h0);
        chk("mid_rst_pc", pc_o, RST_PC);
        imem_ready_i = 1'b1;
        imem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("late_rdy_instr", instr_o, 32'h0);
        chk("late_rdy_valid", 32'(instr_valid_o), 32'd0);
        m_pc = RST_PC;
        fetch(0, {OP_ORI, 26'h2A5_A5A5});
        consume(1, 1'b0, 16'h0, 1'b0, 26'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage sitting directly upstream of the main decoder.
- Holds the PC and issues single-outstanding word reads to instruction memory over a req/ready handshake.
- Presents the fetched instruction, with its PC and PC+4, to decode.
- Computes the next PC from the branch and jump results resolved for the instruction it is presenting.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  read request to instruction memory
imem_addr  output  32  word-aligned fetch address; always equals pc
imem_ready  input  1  read data valid this cycle; honoured only while imem_req=1
imem_rdata  input  32  instruction word returned by memory
instr  output  32  registered instruction presented to decode (Opcode = instr[31:26])
instr_valid  output  1  instr/pc/pc_plus4 hold a valid instruction
pc  output  32  address of the presented instruction
pc_plus4  output  32  pc + 4, modulo 2^32
stall  input  1  downstream holds; instruction is not consumed this cycle
branch_taken  input  1  decoder Branch ANDed with ALU Zero for the presented instruction
branch_imm  input  16  instr[15:0] offset, sign-extended and shifted left by 2
jump  input  1  decoder Jump for the presented instruction
jump_index  input  26  instr[25:0] jump target field

Behaviour:
- States: IDLE, FETCH, VALID. Encoding is binary, held in one state register.
- Reset (asynchronous, immediate):
  - state = IDLE, pc = RESET_PC, instr = 0, instr_valid = 0.
  - imem_req = 0, imem_addr = RESET_PC.
- IDLE -> FETCH unconditionally on the next clk. The first request is therefore asserted one cycle after reset deasserts.
- FETCH:
  - imem_req = 1; imem_addr = pc, held stable until ready.
  - On imem_ready=1 (allowed in the first FETCH cycle, i.e. zero wait states): instr <= imem_rdata, instr_valid <= 1, state -> VALID.
  - Otherwise stay in FETCH; wait states are unbounded.
- VALID:
  - imem_req = 0.
  - If stall=1: hold instr, pc and instr_valid; redirect inputs are ignored.
  - If stall=0 (consume): pc <= next_pc, instr_valid <= 0, state -> FETCH.
- next_pc, evaluated only in the consume cycle. Priority is jump > branch_taken > sequential:
  - jump=1: {pc_plus4[31:28], jump_index, 2'b00}
  - else branch_taken=1: pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00}
  - else: pc_plus4
- Arithmetic: all adds are 32-bit and wrap modulo 2^32 (e.g. 0xFFFF_FFFC + 4 = 0x0000_0000).
- pc_plus4 is combinational from pc. imem_addr[1:0] is always 2'b00.
- Throughput: at most one instruction every 2 cycles with zero-wait memory.
- imem_ready outside FETCH is ignored, including a late ready after a reset mid-fetch. Reset during FETCH abandons the request.
- stall outside VALID has no effect.
- branch_taken and jump outside VALID are don't-care and must not change pc.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE/FETCH/VALID);
  - the default RESET_PC constant;
  - the MIPS opcode constants, reused by the decoder and by bench checkers.
- One combinational sub-module is natural: instr_fetch_next_pc.
  - Inputs: pc_plus4, branch_taken, branch_imm, jump, jump_index.
  - Output: next_pc.
  - The FSM, PC register and instruction register stay in instr_fetch.

Test Plan:
- Reset/sequential: RESET_PC = 0x0040_0000, imem_ready tied 1, stall = 0.
  - imem_req rises 1 cycle after reset release with addr 0x0040_0000.
  - instr_valid is high the next cycle with rdata.
  - Following request addr is 0x0040_0004.
- Wait states: imem_ready delayed 3 cycles.
  - imem_req and imem_addr stay stable for all 4 FETCH cycles.
  - instr_valid rises only after the ready cycle.
  - instr equals the rdata sampled in the ready cycle.
- Branch: pc = 0x0000_0100, branch_taken = 1.
  - imm = 0xFFFF -> next fetch 0x0000_0100.
  - imm = 0x0003 -> next fetch 0x0000_0110.
  - branch_taken = 0 -> next fetch 0x0000_0104.
- Jump priority: pc = 0x1000_0000, jump = 1, jump_index = 0x000_0040, branch_taken = 1 -> next fetch 0x1000_0100.
- Stall: stall held 4 cycles in VALID, with jump = 1 pulsed during the stall and 0 at release.
  - instr, pc and instr_valid are stable and imem_req = 0 throughout.
  - Next fetch is pc + 4.
- Wrap/reset: pc = 0xFFFF_FFFC with no redirect -> next fetch 0x0000_0000.
  - rst asserted mid-FETCH drops outputs to reset values immediately.
  - imem_ready pulsed during IDLE is ignored (instr stays 0).
